pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined, multi-mode barrel shifter; successor to the combinational 32-bit logical right shifter.
- Supports logical left, logical right, arithmetic right and rotate right on an N-bit operand.
- Fully pipelined: one register per shift level, with a valid/ready handshake on input and output.
- Sits between the ALU operand muxes and the writeback mux; a per-request tag travels with each result.

Parameters:
- N, 32, operand width; power of two, N >= 2.
- TAG_W, 4, width of the opaque tag carried alongside each request.
- L (localparam), $clog2(N), number of shift levels; equals pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts a request this cycle.
- in_data  input  N  operand.
- in_shamt  input  L  shift amount, 0..N-1.
- in_op  input  2  shift_op_t: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  shifted result.
- out_tag  output  TAG_W  tag of the request that produced out_data.

Behaviour:
- Reset (rst high at a clock edge): out_valid=0, out_data=0, out_tag=0, every internal stage valid=0, and all data/tag/shamt/op stage registers cleared.
  - Reset mid-operation discards all in-flight requests.
  - in_ready=1 in the first cycle after reset.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Global stall rule: advance = !out_valid || out_ready; in_ready = advance.
  - Combinational from out_ready and the out_valid register; no other combinational in-to-out paths.
- When advance=1, every stage register loads from its predecessor.
  - Stage 0 loads {in_valid, in_data, in_shamt, in_op, in_tag}.
  - A bubble (in_valid=0) loads valid=0 and still propagates.
- When advance=0, all stage registers hold, including out_data and out_tag.
  - Output must stay stable while out_valid && !out_ready.
- Latency is exactly L cycles from input transfer to out_valid, absent stalls; each stall cycle adds one.
- Throughput is one result per cycle when out_ready is held high.
- Level k (k=0..L-1) conditionally shifts by 2^k when shamt[k]=1; otherwise it passes the value through. Level k feeds stage register k.
  - SRL: zero fill from MSB.
  - SRA: fill with the operand's original bit N-1. Bit N-1 is carried through the stages as a sign bit.
  - ROR: bits shifted out of bit 0 re-enter at bit N-1.
  - SLL: bit-reverse the operand at entry, apply SRL, bit-reverse at exit. Reversal happens outside the registers so the latency is unchanged.
- shamt=0 returns in_data unchanged for every op.
- op, shamt and tag are registered alongside data through every stage; upstream may change its inputs after the transfer.
- Simultaneous input transfer and output transfer in the same cycle is legal; the pipeline advances by one.
- No dropped or duplicated results; ordering is strictly FIFO.

Decomposition:
- shifter_pkg contains:
  - typedef enum logic [1:0] shift_op_t {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR}.
  - function bit_reverse, parametrised by width.
- Sub-module shift_level, parameters N and K: purely combinational single level.
  - Inputs: data, enable bit, op, sign.
  - Output: data shifted by 2^K.
  - Instantiated L times in a generate loop; the pipeline registers live in pipelined_shifter.

Test Plan:
- SRA, N=32: in_data=0x8000_0000, shamt=4, tag=3, out_ready=1 -> out_data=0xF800_0000, out_tag=3, out_valid exactly 5 cycles after the transfer.
- ROR and SLL back-to-back: ROR 0x0000_0001 by 1 -> 0x8000_0000; SLL 0x0000_0001 by 31 -> 0x8000_0000; SRL 0xFFFF_FFFF by 16 -> 0x0000_FFFF. Results arrive on consecutive cycles in issue order.
- Backpressure: stream tags 0..7 while out_ready is low for 3 cycles mid-stream -> in_ready=0 during the stall, out_data/out_tag held stable, all 8 results delivered in order with none lost or duplicated.
- Reset mid-flight: issue 3 requests, assert rst for 1 cycle -> out_valid=0 and out_data=0 the next cycle, no stale result ever appears, in_ready=1.
- Exhaustive random: all ops, all shamt 0..31, random data, random in_valid/out_ready -> every result matches the reference model (>>, <<, >>>, rotate). Also check shamt=0 returns in_data for each op.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Shift opcodes plus a width-agnostic bit reversal used to turn SLL into SRL.
package shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_op_t;

   // Widest operand the reversal helper handles; callers zero-extend into it.
   localparam int MAX_W = 256;

   // Reverse the low 'width' bits of value; bits at and above 'width' return 0.
   function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] value,
                                                    input int               width);
      logic [MAX_W-1:0] rev;
      rev = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width) begin
            rev[i] = value[width-1-i];
         end else begin
            rev[i] = 1'b0;
         end
      end
      return rev;
   endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: optionally shifts right by 2**K.
// Fill bits come from the sign (SRA), the low bits (ROR) or zero (SRL/reversed SLL).
module shift_level
   import shifter_pkg::*;
#(
   parameter int N = 32,
   parameter int K = 0
) (
   input  logic [N-1:0] data,
   input  logic         enable,
   input  shift_op_t    op,
   input  logic         sign,
   output logic [N-1:0] result
);

   localparam int S = 2 ** K;

   logic [S-1:0] fill_s;

   // Select fill bits for the vacated MSBs and apply the conditional shift.
   always_comb begin
      fill_s = '0;
      case (op)
         SHIFT_SRA: fill_s = {S{sign}};
         SHIFT_ROR: fill_s = data[S-1:0];
         default:   fill_s = '0;
      endcase
      if (enable) begin
         result = {fill_s, data[N-1:S]};
      end else begin
         result = data;
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined multi-mode barrel shifter: one register stage per shift level,
// global stall on output backpressure, tag carried with each request.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int N     = 32,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_shamt,
   input  shift_op_t            in_op,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int L = $clog2(N);

   logic                        advance_s;
   logic [N-1:0]                entry_data_s;
   logic [N-1:0]                exit_data_s;

   logic [L-1:0]                valid_r;
   logic [L-1:0][N-1:0]         data_r;
   logic [L-1:0][L-1:0]         shamt_r;
   shift_op_t                   op_r [L];
   logic [L-1:0]                sign_r;
   logic [L-1:0][TAG_W-1:0]     tag_r;

   logic [L-1:0][N-1:0]         lvl_in_s;
   logic [L-1:0][N-1:0]         lvl_out_s;
   logic [L-1:0]                lvl_en_s;
   logic [L-1:0]                lvl_sign_s;
   shift_op_t                   lvl_op_s [L];

   assign advance_s = !valid_r[L-1] || out_ready;
   assign in_ready  = advance_s;

   // SLL is computed as SRL on the bit-reversed operand.
   always_comb begin
      if (in_op == SHIFT_SLL) begin
         entry_data_s = N'(bit_reverse(MAX_W'(in_data), N));
      end else begin
         entry_data_s = in_data;
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_level
      if (k == 0) begin : g_first
         assign lvl_in_s[k]   = entry_data_s;
         assign lvl_en_s[k]   = in_shamt[k];
         assign lvl_op_s[k]   = in_op;
         assign lvl_sign_s[k] = in_data[N-1];
      end else begin : g_rest
         assign lvl_in_s[k]   = data_r[k-1];
         assign lvl_en_s[k]   = shamt_r[k-1][k];
         assign lvl_op_s[k]   = op_r[k-1];
         assign lvl_sign_s[k] = sign_r[k-1];
      end

      shift_level #(.N(N), .K(k)) u_level (
         .data   (lvl_in_s[k]),
         .enable (lvl_en_s[k]),
         .op     (lvl_op_s[k]),
         .sign   (lvl_sign_s[k]),
         .result (lvl_out_s[k])
      );
   end

   // Stage registers: all stages advance together or hold together.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
         data_r  <= '0;
         shamt_r <= '0;
         sign_r  <= '0;
         tag_r   <= '0;
         for (int k = 0; k < L; k++) begin
            op_r[k] <= SHIFT_SLL;
         end
      end else if (advance_s) begin
         valid_r[0] <= in_valid;
         data_r[0]  <= lvl_out_s[0];
         shamt_r[0] <= in_shamt;
         op_r[0]    <= in_op;
         sign_r[0]  <= in_data[N-1];
         tag_r[0]   <= in_tag;
         for (int k = 1; k < L; k++) begin
            valid_r[k] <= valid_r[k-1];
            data_r[k]  <= lvl_out_s[k];
            shamt_r[k] <= shamt_r[k-1];
            op_r[k]    <= op_r[k-1];
            sign_r[k]  <= sign_r[k-1];
            tag_r[k]   <= tag_r[k-1];
         end
      end
   end

   // Undo the entry reversal for SLL results; driven only from stage registers.
   always_comb begin
      if (op_r[L-1] == SHIFT_SLL) begin
         exit_data_s = N'(bit_reverse(MAX_W'(data_r[L-1]), N));
      end else begin
         exit_data_s = data_r[L-1];
      end
   end

   assign out_valid = valid_r[L-1];
   assign out_data  = exit_data_s;
   assign out_tag   = tag_r[L-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (N=32): directed table, latency,
// backpressure, mid-flight reset and randomized sweeps against a reference model.
module tb_pipelined_shifter;
   import shifter_pkg::*;

   localparam int N     = 32;
   localparam int TAG_W = 4;
   localparam int L     = 5;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   shift_op_t   in_op;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_tag;

   int   tests = 0;
   int   fails = 0;
   vec_t tbl [15];
   vec_t req_q [$];
   vec_t exp_q [$];

   pipelined_shifter #(.N(N), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
      logic signed [31:0] sd;
      logic [63:0]        dd;
      sd = d;
      dd = {d, d} >> s;
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return sd >>> s;
         default: return dd[31:0];
      endcase
   endfunction

   function automatic vec_t mk(input logic [1:0] op, input logic [31:0] d,
                               input logic [4:0] s, input logic [3:0] t);
      vec_t v;
      v.op = op; v.data = d; v.shamt = s; v.tag = t; v.exp = ref_shift(op, d, s);
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_shamt = '0; in_op = SHIFT_SLL; in_tag = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // Cycle engine: offers req_q, scoreboards outputs against exp_q in order.
   task automatic run(input int budget, input int stall_lo, input int stall_hi, input bit rnd,
                      output int cyc, output int nstall);
      bit          hold_p;
      logic [31:0] hd;
      logic [3:0]  ht;
      vec_t        e;
      cyc = 0; nstall = 0; hold_p = 1'b0; hd = '0; ht = '0;
      while ((req_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (rnd) out_ready = ($urandom_range(0, 2) != 0);
         else     out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         if (req_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_op    = shift_op_t'(req_q[0].op);
            in_data  = req_q[0].data;
            in_shamt = req_q[0].shamt;
            in_tag   = req_q[0].tag;
         end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end
         #1;
         check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
         if (hold_p) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", out_data, hd);
            check("hold_tag", {28'd0, out_tag}, {28'd0, ht});
         end
         if (out_valid && !out_ready) nstall++;
         hold_p = out_valid && !out_ready;
         hd = out_data; ht = out_tag;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e.exp);
               check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
            end
         end
         if (in_valid && in_ready) exp_q.push_back(req_q.pop_front());
      end
      if (req_q.size() > 0 || exp_q.size() > 0) begin
         check("run_timeout", req_q.size() + exp_q.size(), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      req_q.delete(); exp_q.delete();
   endtask

   initial begin
      int  cyc;
      int  ns;
      int  lat;
      bit  stale;

      tbl[0]  = '{2'b10, 32'h8000_0000, 5'd4,  4'd3,  32'hF800_0000};
      tbl[1]  = '{2'b11, 32'h0000_0001, 5'd1,  4'd4,  32'h8000_0000};
      tbl[2]  = '{2'b00, 32'h0000_0001, 5'd31, 4'd5,  32'h8000_0000};
      tbl[3]  = '{2'b01, 32'hFFFF_FFFF, 5'd16, 4'd6,  32'h0000_FFFF};
      tbl[4]  = '{2'b00, 32'h1234_5678, 5'd0,  4'd7,  32'h1234_5678};
      tbl[5]  = '{2'b01, 32'h1234_5678, 5'd0,  4'd8,  32'h1234_5678};
      tbl[6]  = '{2'b10, 32'h8765_4321, 5'd0,  4'd9,  32'h8765_4321};
      tbl[7]  = '{2'b11, 32'h8765_4321, 5'd0,  4'd10, 32'h8765_4321};
      tbl[8]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 4'd11, 32'h0000_0000};
      tbl[9]  = '{2'b10, 32'h8000_0000, 5'd31, 4'd12, 32'hFFFF_FFFF};
      tbl[10] = '{2'b11, 32'h1234_5678, 5'd8,  4'd13, 32'h7812_3456};
      tbl[11] = '{2'b00, 32'h0000_FFFF, 5'd4,  4'd14, 32'h000F_FFF0};
      tbl[12] = '{2'b01, 32'h8000_0000, 5'd31, 4'd15, 32'h0000_0001};
      tbl[13] = '{2'b11, 32'h8000_0001, 5'd31, 4'd0,  32'h0000_0003};
      tbl[14] = '{2'b10, 32'hC000_0000, 5'd1,  4'd1,  32'hE000_0000};

      // Reset state
      do_reset();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_tag", {28'd0, out_tag}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single SRA request: latency of exactly L cycles
      @(negedge clk);
      in_valid = 1'b1; in_op = SHIFT_SRA; in_data = 32'h8000_0000; in_shamt = 5'd4; in_tag = 4'd3;
      #1;
      check("lat_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_data = 32'h0; in_shamt = 5'd0; in_tag = 4'd0;
      #1;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      check("lat_cycles", lat, 32'd5);
      check("lat_data", out_data, 32'hF800_0000);
      check("lat_tag", {28'd0, out_tag}, 32'd3);
      @(negedge clk);

      // Directed table streamed back-to-back: results on consecutive cycles
      for (int i = 0; i < 15; i++) req_q.push_back(tbl[i]);
      run(100, 1000, 1000, 1'b0, cyc, ns);
      check("table_cycles", cyc, 32'(15 + L));

      // Backpressure: 3-cycle stall while the stream is in flight
      for (int i = 0; i < 8; i++) req_q.push_back(mk(2'b01, 32'hF000_0000, 5'(i), 4'(i)));
      run(100, 6, 8, 1'b0, cyc, ns);
      check("bp_stall_cycles", ns, 32'd3);

      // Reset while three requests are in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = SHIFT_ROR; in_data = 32'hDEAD_BEEF; in_shamt = 5'(i + 1);
         in_tag = 4'(i + 1);
      end
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_out_data", out_data, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) stale = 1'b1;
      end
      check("mid_rst_no_stale", {31'd0, stale}, 32'd0);

      // All ops x all shift amounts plus extra random, with random handshakes
      for (int op = 0; op < 4; op++) begin
         for (int s = 0; s < 32; s++) req_q.push_back(mk(2'(op), $urandom, 5'(s), 4'($urandom)));
      end
      for (int i = 0; i < 64; i++) begin
         req_q.push_back(mk(2'($urandom), $urandom, 5'($urandom), 4'($urandom)));
      end
      run(3000, 0, 0, 1'b1, cyc, ns);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
